seg_display_ctrl: RTL and testbench

Multi-digit seven-segment display controller. It is the parametrised successor of the single-digit hex decoder. It accepts a binary value on a load strobe and shows it in hex mode or unsigned decimal mode across DIGITS active-low displays. Decimal mode uses a sequential double-dabble converter. The block also provides leading-zero blanking, per-digit decimal points, per-digit blinking and overflow indication. It sits between application logic and the board's HEX outputs.

---
 rtl/seg_display_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: multi-digit active-low seven-segment controller.
// Shows a loaded binary value in hex or unsigned decimal (double-dabble),
// with leading-zero blanking, per-digit decimal points, blinking and an
// overflow indication. A digit stage holds what is shown; an output stage
// registers the decoded segments one cycle later.
module seg_display_ctrl #(
  parameter int DIGITS    = 6,
  parameter int VAL_W     = 20,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  mode,
  input  logic [VAL_W-1:0]      value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [8*DIGITS-1:0]   HEX
);

  // BCD accumulator is wide enough for any legal VAL_W, so the digits above
  // DIGITS-1 exist only to detect overflow.
  localparam int ACC_D = DIGITS + DIGITS / 2 + 1;
  localparam int ACC_W = 4 * ACC_D;
  localparam int DIG_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL_W - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } state_t;

  state_t state;
  state_t state_next;

  // Control strobes produced by the FSM.
  logic start_conv;
  logic hex_commit;
  logic dec_commit;

  // Conversion datapath.
  logic [VAL_W-1:0]   shift_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W:0]     acc_shift;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DIGITS-1:0]  pend_dp;

  // Digit stage.
  logic [DIG_W-1:0]   digit_reg;
  logic [DIGITS-1:0]  dp_reg;
  logic               ovf_reg;
  logic               mode_reg;
  logic               written;
  logic               done_reg;

  // Blink timebase.
  logic [BLK_W-1:0]   blink_cnt;
  logic               blink_phase;

  // Output stage.
  logic [8*DIGITS-1:0] hex_next;
  logic [8*DIGITS-1:0] hex_reg;

  logic [DIG_W-1:0]   val_ext;

  // Active-low glyphs for one hex nibble, segments g..a, dp excluded.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Zero-extend the input value to a whole number of nibbles.
  always_comb begin
    val_ext = '0;
    val_ext[VAL_W-1:0] = value;
  end

  // FSM state register; leaving reset always aborts a conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and strobes; loads are only accepted while idle.
  always_comb begin
    state_next = state;
    start_conv = 1'b0;
    hex_commit = 1'b0;
    dec_commit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          if (mode) begin
            start_conv = 1'b1;
            state_next = ST_CONV;
          end else begin
            hex_commit = 1'b1;
          end
        end
      end
      ST_CONV: begin
        if (bit_cnt == CNT_LAST) begin
          dec_commit = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Add-3 correction on every BCD digit that is 5 or more.
  generate
    for (genvar gi = 0; gi < ACC_D; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                  acc_reg[4*gi +: 4] + 4'd3 :
                                  acc_reg[4*gi +: 4];
    end
  endgenerate

  // One extra bit on top so nothing shifted out could go unnoticed.
  assign acc_shift = {acc_adj, shift_reg[VAL_W-1]};

  // Double-dabble shift register, accumulator and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      acc_reg   <= '0;
      bit_cnt   <= '0;
      pend_dp   <= '0;
    end else if (start_conv) begin
      shift_reg <= value;
      acc_reg   <= '0;
      bit_cnt   <= '0;
      pend_dp   <= dp;
    end else if (state == ST_CONV) begin
      shift_reg <= shift_reg << 1;
      acc_reg   <= acc_shift[ACC_W-1:0];
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

  // Digit stage: commits hex nibbles directly or the finished BCD digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_reg <= '0;
      dp_reg    <= '0;
      ovf_reg   <= 1'b0;
      mode_reg  <= 1'b0;
      written   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= hex_commit | dec_commit;
      if (hex_commit) begin
        digit_reg <= val_ext;
        dp_reg    <= dp;
        ovf_reg   <= 1'b0;
        mode_reg  <= 1'b0;
        written   <= 1'b1;
      end else if (dec_commit) begin
        digit_reg <= acc_shift[DIG_W-1:0];
        dp_reg    <= pend_dp;
        ovf_reg   <= |acc_shift[ACC_W:DIG_W];
        mode_reg  <= 1'b1;
        written   <= 1'b1;
      end
    end
  end

  // Free-running blink timebase; phase flips once per BLINK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

  // Per-digit glyph selection. Priority: never written, blink-off,
  // overflow dash, leading-zero blank, normal glyph.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic       lead_zero;
      logic [6:0] segs;
      logic       dot;

      if (gi == 0) begin : g_lsd
        // The rightmost digit is always shown so zero reads as "0".
        assign lead_zero = 1'b0;
      end else begin : g_upper
        assign lead_zero = blank_en & ~(|digit_reg[DIG_W-1:4*gi]);
      end

      // Decode one digit from the digit stage and the live display controls.
      always_comb begin
        segs = seg_of(digit_reg[4*gi +: 4]);
        dot  = dp_reg[gi];
        if (!written) begin
          segs = SEG_BLANK;
          dot  = 1'b0;
        end else if (blink_phase && blink_mask[gi]) begin
          segs = SEG_BLANK;
          dot  = 1'b0;
        end else if (ovf_reg && mode_reg) begin
          segs = SEG_DASH;
        end else if (lead_zero) begin
          segs = SEG_BLANK;
        end
      end

      assign hex_next[8*gi +: 8] = {~dot, segs};
    end
  endgenerate

  // Output stage: segments lag the digit stage by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_reg <= '1;
    end else begin
      hex_reg <= hex_next;
    end
  end

  assign HEX  = hex_reg;
  assign busy = (state == ST_CONV);
  assign done = done_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Testbench for seg_display_ctrl: random stimulus against a behavioural
// model (decimal digits via division, blink phase from elapsed cycles),
// plus literal expectations for the documented display scenarios.
module tb_seg_display_ctrl;
  localparam int DIGITS    = 6;
  localparam int VAL_W     = 20;
  localparam int BLINK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        mode = 1'b0;
  logic [19:0] value = '0;
  logic [5:0]  dp = '0;
  logic        blank_en = 1'b0;
  logic [5:0]  blink_mask = '0;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [47:0] HEX;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .DIGITS   (DIGITS),
    .VAL_W    (VAL_W),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .mode      (mode),
    .value     (value),
    .dp        (dp),
    .blank_en  (blank_en),
    .blink_mask(blink_mask),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .HEX       (HEX)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Behavioural model state: what the display shows and what is pending.
  bit          m_written;
  int          m_digit [6];
  bit [5:0]    m_dp;
  bit          m_ovf;
  int          m_busy_left;
  int          m_pend_val;
  bit [5:0]    m_pend_dp;
  bit          m_done;
  int          m_edges;
  logic [47:0] m_hex;

  task automatic check_hex(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] expected_hex(input bit phase);
    logic [47:0] r;
    logic [7:0]  b;
    bit          upper_zero;
    r = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!m_written || (phase && blink_mask[i])) begin
        b = 8'hFF;
      end else begin
        upper_zero = 1'b1;
        for (int j = i; j < DIGITS; j++) begin
          if (m_digit[j] != 0) upper_zero = 1'b0;
        end
        if (m_ovf) b = 8'hBF;
        else if (blank_en && i > 0 && upper_zero) b = 8'hFF;
        else b = seg_tab[m_digit[i]];
        if (m_dp[i]) b[7] = 1'b0;
      end
      r[8*i +: 8] = b;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_written = 1'b0;
    for (int i = 0; i < DIGITS; i++) m_digit[i] = 0;
    m_dp = '0;
    m_ovf = 1'b0;
    m_busy_left = 0;
    m_pend_val = 0;
    m_pend_dp = '0;
    m_done = 1'b0;
    m_edges = 0;
    m_hex = '1;
  endtask

  task automatic model_step();
    int v;
    m_hex = expected_hex(((m_edges / BLINK_DIV) % 2) == 1);
    m_edges++;
    m_done = 1'b0;
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        v = m_pend_val;
        m_ovf = (v > 999999);
        for (int i = 0; i < DIGITS; i++) begin
          m_digit[i] = v % 10;
          v = v / 10;
        end
        m_dp = m_pend_dp;
        m_written = 1'b1;
        m_done = 1'b1;
      end
    end else if (load) begin
      if (!mode) begin
        for (int i = 0; i < DIGITS; i++) m_digit[i] = int'((value >> (4 * i)) & 20'hF);
        m_dp = dp;
        m_ovf = 1'b0;
        m_written = 1'b1;
        m_done = 1'b1;
      end else begin
        m_busy_left = VAL_W;
        m_pend_val = int'(value);
        m_pend_dp = dp;
      end
    end
  endtask

  // Model advances on every clock edge and resets asynchronously.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      check_hex("model_HEX", HEX, m_hex);
      check_bit("model_busy", busy, m_busy_left > 0);
      check_bit("model_done", done, m_done);
      check_bit("model_ovf", ovf, m_ovf);
    end
  end

  // Pulse load for one cycle, then wait for done and one more edge for HEX.
  task automatic run_load(input logic m, input logic [19:0] v, input logic [5:0] d, output int lat);
    mode = m;
    value = v;
    dp = d;
    load = 1'b1;
    lat = 0;
    @(posedge clk);
    #1 load = 1'b0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles at %0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int cnt_on;
    int cnt_off;
    int sel;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check_hex("reset_HEX", HEX, 48'hFFFF_FFFF_FFFF);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_ovf", ovf, 1'b0);
    @(posedge clk);
    #1;

    // Hex mode
    run_load(1'b0, 20'h0A3F5, 6'b0, lat);
    check_int("hex_latency", lat, 0);
    check_hex("hex_0A3F5", HEX, 48'hC0C0_88B0_8E92);

    // Decimal mode with a load attempt during the conversion
    mode = 1'b1;
    value = 20'd123456;
    dp = 6'b001000;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (c == 5) begin
        load = 1'b1;
        mode = 1'b0;
        value = 20'hFFFFF;
        dp = 6'b111111;
      end
      @(posedge clk);
      #1 load = 1'b0;
      lat = c;
    end
    check_int("dec_latency", lat, 20);
    @(posedge clk);
    #1;
    check_hex("dec_123456", HEX, 48'hF9A4_3099_9282);

    // Overflow then recovery
    run_load(1'b1, 20'd1000000, 6'b0, lat);
    check_bit("ovf_set", ovf, 1'b1);
    check_hex("ovf_dash", HEX, 48'hBFBF_BFBF_BFBF);
    run_load(1'b1, 20'd7, 6'b0, lat);
    check_bit("ovf_clear", ovf, 1'b0);
    check_hex("dec_7", HEX, 48'hC0C0_C0C0_C0F8);

    // Leading-zero blanking
    blank_en = 1'b1;
    run_load(1'b1, 20'd42, 6'b0, lat);
    check_hex("blank_42", HEX, 48'hFFFF_FFFF_99A4);
    run_load(1'b1, 20'd0, 6'b0, lat);
    check_hex("blank_0", HEX, 48'hFFFF_FFFF_FFC0);
    run_load(1'b1, 20'd42, 6'b0, lat);
    blank_en = 1'b0;
    @(posedge clk);
    #1;
    check_hex("unblank_42", HEX, 48'hC0C0_C0C0_99A4);

    // Blink digit 0 only
    blank_en = 1'b1;
    blink_mask = 6'b000001;
    @(posedge clk);
    #1;
    cnt_on = 0;
    cnt_off = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (HEX[7:0] == 8'hA4) cnt_on++;
      if (HEX[7:0] == 8'hFF) cnt_off++;
      check_hex("blink_digit1", {40'h0, HEX[15:8]}, 48'h99);
    end
    check_int("blink_on_cycles", cnt_on, 8);
    check_int("blink_off_cycles", cnt_off, 8);
    blink_mask = 6'b0;
    @(posedge clk);
    #1;
    check_hex("blink_cleared", {40'h0, HEX[7:0]}, 48'hA4);

    // Reset in the middle of a conversion
    mode = 1'b1;
    value = 20'd99999;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_bit("midreset_busy", busy, 1'b0);
    check_hex("midreset_HEX", HEX, 48'hFFFF_FFFF_FFFF);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      load = ($urandom_range(0, 3) == 0);
      mode = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       value = 20'($urandom_range(0, 99));
        1:       value = 20'($urandom_range(0, 999999));
        2:       value = 20'($urandom_range(0, 20'hFFFFF));
        default: value = 20'($urandom_range(999990, 1000010));
      endcase
      dp = 6'($urandom);
      if ($urandom_range(0, 15) == 0) blank_en = ~blank_en;
      if ($urandom_range(0, 31) == 0) blink_mask = 6'($urandom);
    end
    load = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
